// File: rtl/ldce_bank_writer.sv
// Write sequencer for a bank of LDCE transparent latches: times D setup, a one-cycle gate pulse and D hold.
// Optional shadow copy of the latch contents, readable on RD_DATA, enabled by defining LDW_SHADOW_EN.
module ldce_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             WR_VALID,
    output logic             WR_READY,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             CLR_REQ,
    output logic [WIDTH-1:0] LD_D,
    output logic [DEPTH-1:0] LD_G,
    output logic             LD_GE,
    output logic             LD_CLR,
    output logic             BUSY,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [WIDTH-1:0] RD_DATA
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_GATE  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_CLEAR = 3'd4;

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [3:0]       cnt_r;
    logic [3:0]       cnt_nxt_s;
    logic [AW-1:0]    addr_r;
    logic [WIDTH-1:0] ld_d_r;
    logic [DEPTH-1:0] ld_g_r;
    logic             ld_ge_r;
    logic             ld_clr_r;
    logic             busy_r;
    logic             accept_s;
    logic             addr_ok_s;

    // Out-of-range addresses decode to no gate at all.
    function automatic logic [DEPTH-1:0] gate_decode(input logic [AW-1:0] a);
        logic [DEPTH-1:0] g;
        g = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (32'(a) == i) begin
                g[i] = 1'b1;
            end else begin
                g[i] = 1'b0;
            end
        end
        return g;
    endfunction

    assign WR_READY  = (state_r == ST_IDLE) && !CLR_REQ;
    assign accept_s  = WR_VALID && WR_READY;
    assign addr_ok_s = (32'(addr_r) < DEPTH);

    // Next-state and setup/hold counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (CLR_REQ) begin
                    state_nxt_s = ST_CLEAR;
                end else if (WR_VALID) begin
                    state_nxt_s = ST_SETUP;
                    cnt_nxt_s   = 4'(SETUP_CYC - 1);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_GATE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_GATE: begin
                state_nxt_s = ST_HOLD;
                cnt_nxt_s   = 4'(HOLD_CYC - 1);
            end
            ST_HOLD: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_CLEAR: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, captured request and registered latch-pin drivers (decoded from the next state).
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= '0;
            ld_d_r   <= '0;
            ld_g_r   <= '0;
            ld_ge_r  <= 1'b0;
            ld_clr_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            if (accept_s) begin
                addr_r <= WR_ADDR;
                ld_d_r <= WR_DATA;
            end else begin
                addr_r <= addr_r;
                ld_d_r <= ld_d_r;
            end
            ld_g_r   <= (state_nxt_s == ST_GATE) ? gate_decode(addr_r) : '0;
            ld_ge_r  <= (state_nxt_s == ST_GATE);
            ld_clr_r <= (state_nxt_s == ST_CLEAR);
            busy_r   <= (state_nxt_s != ST_IDLE);
        end
    end

    assign LD_D   = ld_d_r;
    assign LD_G   = ld_g_r;
    assign LD_GE  = ld_ge_r;
    assign LD_CLR = ld_clr_r;
    assign BUSY   = busy_r;

`ifdef LDW_SHADOW_EN
    logic [WIDTH-1:0] shadow_r [DEPTH];
    logic [WIDTH-1:0] rd_data_s;

    // Shadow copy follows the latches: written as the gate closes, wiped by CLEAR.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_r[i] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_r[i] <= '0;
            end
        end else if ((state_r == ST_GATE) && addr_ok_s) begin
            shadow_r[addr_r] <= ld_d_r;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                shadow_r[i] <= shadow_r[i];
            end
        end
    end

    // Combinational shadow read with out-of-range guard.
    always_comb begin
        rd_data_s = '0;
        if (32'(RD_ADDR) < DEPTH) begin
            rd_data_s = shadow_r[RD_ADDR];
        end else begin
            rd_data_s = '0;
        end
    end

    assign RD_DATA = rd_data_s;
`else
    logic unused_rd_s;
    logic unused_addr_ok_s;

    assign unused_rd_s      = ^RD_ADDR;
    assign unused_addr_ok_s = addr_ok_s;
    assign RD_DATA          = '0;
`endif

endmodule
